bit_serial_ctrl: RTL
====================

Name: bit_serial_ctrl

Overview:
- Sequencer for the bit-serial ALU datapath inside the DE0 demo design.
- Accepts a start request and 2-bit opcode, then steps the datapath through operand load, WIDTH serial bit cycles and result write-back.
- Drives all datapath strobes: load, shift, carry preset, B-operand conditioning, write enable.
- Single clock domain; runs on the slow (~10 Hz) demo clock or any faster clock.

Parameters:
- WIDTH, 4, operand width in bits = number of serial SHIFT cycles (must be >= 2).
- CW, $clog2(WIDTH), width of bit_idx.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  synchronous reset, active low.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 PASS (A+0), 11 INC (A+0+1); latched on accepted start.
- busy  out  1  high in LOAD, SHIFT and WRITE.
- done  out  1  one-cycle pulse, coincident with result_we.
- load_en  out  1  parallel-load operand shift registers.
- carry_load  out  1  preset datapath carry flop with carry_init.
- carry_init  out  1  1 for SUB/INC, else 0; valid while carry_load=1.
- shift_en  out  1  advance serial registers and carry by one bit.
- b_invert  out  1  invert serial B bit (SUB); held for the whole operation.
- b_zero  out  1  force serial B bit to 0 (PASS/INC); held for the whole operation.
- bit_idx  out  CW  current bit position, LSB first.
- result_we  out  1  write the result register.

Behaviour:
- Reset: on any rising clk with n_reset=0, state <= IDLE, op_q <= 00, bit counter <= 0. Every output is 0 in the following cycle. Reset mid-operation aborts it with no done pulse.
- States: IDLE, LOAD, SHIFT, WRITE. All outputs are Moore, decoded from registered state/op_q/counter.
- IDLE: busy=0. If start=1, then op_q <= op and go to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle): load_en=1, carry_load=1, carry_init=(op_q==01 or op_q==11). Then go to SHIFT with counter=0.
- SHIFT (WIDTH cycles): shift_en=1, bit_idx=counter. Counter increments each cycle. At counter==WIDTH-1, go to WRITE and clear the counter; no wrap past WIDTH-1.
- WRITE (1 cycle): result_we=1, done=1. Then go to IDLE unconditionally.
- b_invert = busy & (op_q==01). b_zero = busy & op_q[1]. bit_idx = 0 outside SHIFT.
- Latency: start sampled at edge N gives LOAD in cycle N+1, SHIFT in N+2..N+WIDTH+1, WRITE/done in N+WIDTH+2.
- start high during LOAD/SHIFT/WRITE is ignored, with no queuing. start held high continuously re-issues after one IDLE cycle, giving a period of WIDTH+3 cycles.
- op changes after acceptance are ignored until the next accepted start.

Optional Feature:
- Macro BIT_SERIAL_CTRL_STEP_EN.
- Defined:
  - Adds input port step (1 bit, after start).
  - In SHIFT, shift_en = step (combinational), and the counter advances and the exit to WRITE occur only on cycles with step=1.
  - LOAD, WRITE and IDLE are unaffected.
  - Supports single-stepping the bit-serial datapath from a debounced switch.
- Undefined: step port absent; SHIFT free-runs as described above.

Test Plan:
- Reset: n_reset=0 for 2 cycles with start=1, op=01 -> all outputs 0, busy=0, and no LOAD in the cycle after release unless start is still high.
- SUB, WIDTH=4, start pulse at cycle 0 -> cycle 1 load_en=carry_load=carry_init=1; cycles 2-5 shift_en=1, bit_idx=0,1,2,3, b_invert=1; cycle 6 result_we=done=1; cycle 7 busy=0.
- INC, op=11 -> carry_init=1 in LOAD, b_zero=1 and b_invert=0 in cycles 1-6. ADD, op=00 -> carry_init=0, b_zero=0, b_invert=0.
- start held high, op=00 -> done at cycles 6, 13, 20 (period 7); start during busy never shortens or extends an operation.
- Reset asserted while bit_idx=2 in an op=01 run -> IDLE next cycle, no done. New start with op=00 -> carry_init=0 and b_invert=0, so op_q is not stale. Changing op 00->01 during SHIFT -> b_invert stays 0.
- BIT_SERIAL_CTRL_STEP_EN defined, step pulsed every 3rd cycle -> shift_en only on step cycles, bit_idx 0..3 across 4 pulses, WRITE on the cycle after the 4th pulse.

Source files
------------

// File: rtl/bit_serial_ctrl.sv
// Sequencer for the bit-serial ALU: IDLE -> LOAD -> WIDTH x SHIFT -> WRITE -> IDLE.
// Latency: start sampled at edge N gives LOAD at N+1, SHIFT N+2..N+WIDTH+1, WRITE/done at N+WIDTH+2.
// Backpressure: start is only sampled in IDLE (no queuing); optional BIT_SERIAL_CTRL_STEP_EN gates SHIFT with step.
module bit_serial_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
`ifdef BIT_SERIAL_CTRL_STEP_EN
    input  logic          step,
`endif
    input  logic [1:0]    op,
    output logic          busy,
    output logic          done,
    output logic          load_en,
    output logic          carry_load,
    output logic          carry_init,
    output logic          shift_en,
    output logic          b_invert,
    output logic          b_zero,
    output logic [CW-1:0] bit_idx,
    output logic          result_we
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0]    OP_SUB   = 2'b01;
    localparam logic [1:0]    OP_INC   = 2'b11;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          adv;

    // SHIFT advances every cycle unless single-stepping is built in.
`ifdef BIT_SERIAL_CTRL_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // Next-state, opcode latch and bit counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (adv) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode of the registered state; only shift_en sees step combinationally.
    assign busy       = (state_q != S_IDLE);
    assign load_en    = (state_q == S_LOAD);
    assign carry_load = (state_q == S_LOAD);
    assign carry_init = (state_q == S_LOAD) & ((op_q == OP_SUB) | (op_q == OP_INC));
    assign shift_en   = (state_q == S_SHIFT) & adv;
    assign bit_idx    = (state_q == S_SHIFT) ? cnt_q : '0;
    assign result_we  = (state_q == S_WRITE);
    assign done       = (state_q == S_WRITE);
    assign b_invert   = busy & (op_q == OP_SUB);
    assign b_zero     = busy & op_q[1];

endmodule
